// File: rtl/wtsum_topk_select_if.sv
// wtsum_topk_select_if
// Bundles the patch input stream, the ranked output stream and the status
// flags of wtsum_topk_select.
//   slave  : the top-K selector (consumes in_*, out_ready; drives out_*, flags)
//   master : the surrounding logic / bench (drives in_*, out_ready)
// Signals:
//   in_valid, in_patch_num, in_wtsum          patch result stream, no backpressure
//   out_valid, out_ready                      ranked result handshake
//   out_rank, out_patch_num, out_wtsum, out_last
//   frame_done, seq_err, overrun              status
//   min_wtsum                                 only with TOPK_THRESHOLD_EN defined
`timescale 1ns/1ps
interface wtsum_topk_select_if #(
  parameter int FP_SIZE = 32,
  parameter int N_PATCH = 1024,
  parameter int TOP_K   = 8
);
  localparam int PW = (N_PATCH > 1) ? $clog2(N_PATCH) : 1;
  localparam int RW = $clog2(TOP_K) + 1;

  logic               in_valid;
  logic [PW-1:0]      in_patch_num;
  logic [FP_SIZE-1:0] in_wtsum;
  logic               out_valid;
  logic               out_ready;
  logic [RW-1:0]      out_rank;
  logic [PW-1:0]      out_patch_num;
  logic [FP_SIZE-1:0] out_wtsum;
  logic               out_last;
  logic               frame_done;
  logic               seq_err;
  logic               overrun;
`ifdef TOPK_THRESHOLD_EN
  logic [FP_SIZE-1:0] min_wtsum;
`endif

  modport slave (
    input  in_valid, in_patch_num, in_wtsum, out_ready,
    output out_valid, out_rank, out_patch_num, out_wtsum, out_last,
    output frame_done, seq_err, overrun
`ifdef TOPK_THRESHOLD_EN
    , input min_wtsum
`endif
  );

  modport master (
    output in_valid, in_patch_num, in_wtsum, out_ready,
    input  out_valid, out_rank, out_patch_num, out_wtsum, out_last,
    input  frame_done, seq_err, overrun
`ifdef TOPK_THRESHOLD_EN
    , output min_wtsum
`endif
  );
endinterface

// File: rtl/wtsum_topk_select.sv
// wtsum_topk_select
// Keeps the TOP_K largest wtsum values of the current frame (sorted, rank 0 =
// largest, ties keep the earlier patch higher). On the last patch of a frame
// the list is copied into an output bank and drained rank 0 first over a
// valid/ready handshake while the next frame accumulates.
// Ports:
//   CLK    : clock
//   RESET  : asynchronous active-low reset
//   bus    : wtsum_topk_select_if.slave (input stream, output stream, flags)
// Optional build macro TOPK_THRESHOLD_EN: adds bus.min_wtsum; beats below it
// are not inserted but still advance the sequence check and end the frame.
`timescale 1ns/1ps
module wtsum_topk_select #(
  parameter int DELAY   = 1,
  parameter int FP_SIZE = 32,
  parameter int N_PATCH = 1024,
  parameter int TOP_K   = 8
) (
  input  logic CLK,
  input  logic RESET,
  wtsum_topk_select_if.slave bus
);
  localparam int PW = (N_PATCH > 1) ? $clog2(N_PATCH) : 1;
  localparam int RW = $clog2(TOP_K) + 1;
  localparam int IW = (TOP_K > 1) ? $clog2(TOP_K) : 1;
  localparam logic [PW:0]   N_PATCH_W = (PW+1)'(N_PATCH);
  localparam logic [PW-1:0] LAST_P    = PW'(N_PATCH - 1);

  // Registers update without delay in this synthesizable form; DELAY only
  // takes part in the parameter sanity check.
  if (TOP_K < 1 || TOP_K > N_PATCH || DELAY < 0) begin : g_param_chk
    $error("wtsum_topk_select: illegal parameter set");
  end

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DRAIN = 1'b1} state_t;

  // Working list
  logic [TOP_K-1:0]              v_q, v_d;
  logic [TOP_K-1:0][PW-1:0]      pn_q, pn_d;
  logic [TOP_K-1:0][FP_SIZE-1:0] wt_q, wt_d;
  logic [PW-1:0]                 exp_q, exp_d;
  // Output bank
  logic [TOP_K-1:0][PW-1:0]      bpn_q, bpn_d;
  logic [TOP_K-1:0][FP_SIZE-1:0] bwt_q, bwt_d;
  logic [RW-1:0]                 cnt_q, cnt_d;
  state_t                        state_q, state_d;
  // Registered outputs
  logic                          ov_q, ov_d;
  logic [RW-1:0]                 orank_q, orank_d;
  logic [PW-1:0]                 opn_q, opn_d;
  logic [FP_SIZE-1:0]            owt_q, owt_d;
  logic                          olast_q, olast_d;
  logic                          fdone_q, fdone_d;
  logic                          serr_q, serr_d;
  logic                          ovr_q, ovr_d;

  // Combinational helpers
  logic                          in_range_s, thr_ok_s, ins_s, eof_s;
  logic [TOP_K:0]                gtx_s;   // gtx_s[i+1] = gt[i], gtx_s[0] = 0
  logic [TOP_K-1:0]              nv_s;
  logic [TOP_K-1:0][PW-1:0]      npn_s;
  logic [TOP_K-1:0][FP_SIZE-1:0] nwt_s;
  logic [RW-1:0]                 ncnt_s;
  logic                          xfer_s, bank_free_s, load_s, drop_s;
  logic [RW-1:0]                 nxt_rank_s;
  logic [IW-1:0]                 nxt_idx_s;

  // Post-insertion list: one new beat slides into place, lower entries shift down.
  always_comb begin
    in_range_s = ({1'b0, bus.in_patch_num} < N_PATCH_W);
`ifdef TOPK_THRESHOLD_EN
    thr_ok_s = (bus.in_wtsum >= bus.min_wtsum);
`else
    thr_ok_s = 1'b1;
`endif
    ins_s = bus.in_valid && in_range_s && thr_ok_s;
    eof_s = bus.in_valid && (bus.in_patch_num == LAST_P);
    gtx_s = '0;
    for (int i = 0; i < TOP_K; i++) begin
      gtx_s[i+1] = !v_q[i] || (bus.in_wtsum > wt_q[i]);
    end
    nv_s  = v_q;
    npn_s = pn_q;
    nwt_s = wt_q;
    if (ins_s) begin
      // gt is monotone down the list, so shift and load slots never overlap.
      for (int i = 1; i < TOP_K; i++) begin
        if (gtx_s[i]) begin
          nv_s[i]  = v_q[i-1];
          npn_s[i] = pn_q[i-1];
          nwt_s[i] = wt_q[i-1];
        end
      end
      for (int i = 0; i < TOP_K; i++) begin
        if (gtx_s[i+1] && !gtx_s[i]) begin
          nv_s[i]  = 1'b1;
          npn_s[i] = bus.in_patch_num;
          nwt_s[i] = bus.in_wtsum;
        end
      end
    end else begin
      nv_s = v_q;
    end
    ncnt_s = '0;
    for (int i = 0; i < TOP_K; i++) begin
      ncnt_s = ncnt_s + RW'(nv_s[i]);
    end
  end

  // Working list next state and sequence tracking.
  always_comb begin
    serr_d = serr_q;
    exp_d  = exp_q;
    if (eof_s) begin
      v_d  = '0;
      pn_d = '0;
      wt_d = '0;
    end else begin
      v_d  = nv_s;
      pn_d = npn_s;
      wt_d = nwt_s;
    end
    if (bus.in_valid) begin
      if (!in_range_s) begin
        serr_d = 1'b1;
      end else begin
        if (bus.in_patch_num != exp_q) begin
          serr_d = 1'b1;
        end else begin
          serr_d = serr_q;
        end
        exp_d = (bus.in_patch_num == LAST_P) ? '0 : bus.in_patch_num + PW'(1);
      end
    end else begin
      exp_d = exp_q;
    end
  end

  // Drain FSM: bank load/drop decisions and the presented entry.
  always_comb begin
    xfer_s      = ov_q && bus.out_ready;
    // The final transfer frees the bank on the same edge a new snapshot lands.
    bank_free_s = (state_q == ST_IDLE) || (xfer_s && olast_q);
    load_s      = eof_s && (ncnt_s != '0) && bank_free_s;
    drop_s      = eof_s && (ncnt_s != '0) && !bank_free_s;
    nxt_rank_s  = orank_q + RW'(1);
    nxt_idx_s   = IW'(nxt_rank_s);
    fdone_d     = eof_s;
    ovr_d       = ovr_q || drop_s;
    state_d     = state_q;
    ov_d        = ov_q;
    orank_d     = orank_q;
    opn_d       = opn_q;
    owt_d       = owt_q;
    olast_d     = olast_q;
    if (load_s) begin
      bpn_d = npn_s;
      bwt_d = nwt_s;
      cnt_d = ncnt_s;
    end else begin
      bpn_d = bpn_q;
      bwt_d = bwt_q;
      cnt_d = cnt_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (load_s) begin
          state_d = ST_DRAIN;
          ov_d    = 1'b1;
          orank_d = '0;
          opn_d   = npn_s[0];
          owt_d   = nwt_s[0];
          olast_d = (ncnt_s == RW'(1));
        end else begin
          ov_d    = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (xfer_s && olast_q) begin
          if (load_s) begin
            ov_d    = 1'b1;
            orank_d = '0;
            opn_d   = npn_s[0];
            owt_d   = nwt_s[0];
            olast_d = (ncnt_s == RW'(1));
          end else begin
            state_d = ST_IDLE;
            ov_d    = 1'b0;
            olast_d = 1'b0;
          end
        end else if (xfer_s) begin
          ov_d    = 1'b1;
          orank_d = nxt_rank_s;
          opn_d   = bpn_q[nxt_idx_s];
          owt_d   = bwt_q[nxt_idx_s];
          olast_d = (nxt_rank_s == cnt_q - RW'(1));
        end else begin
          ov_d    = ov_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ov_d    = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      v_q     <= '0;
      pn_q    <= '0;
      wt_q    <= '0;
      exp_q   <= '0;
      bpn_q   <= '0;
      bwt_q   <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      ov_q    <= 1'b0;
      orank_q <= '0;
      opn_q   <= '0;
      owt_q   <= '0;
      olast_q <= 1'b0;
      fdone_q <= 1'b0;
      serr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      v_q     <= v_d;
      pn_q    <= pn_d;
      wt_q    <= wt_d;
      exp_q   <= exp_d;
      bpn_q   <= bpn_d;
      bwt_q   <= bwt_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      ov_q    <= ov_d;
      orank_q <= orank_d;
      opn_q   <= opn_d;
      owt_q   <= owt_d;
      olast_q <= olast_d;
      fdone_q <= fdone_d;
      serr_q  <= serr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.out_valid     = ov_q;
  assign bus.out_rank      = orank_q;
  assign bus.out_patch_num = opn_q;
  assign bus.out_wtsum     = owt_q;
  assign bus.out_last      = olast_q;
  assign bus.frame_done    = fdone_q;
  assign bus.seq_err       = serr_q;
  assign bus.overrun       = ovr_q;
endmodule

// File: tb/tb_wtsum_topk_select.sv
// tb_wtsum_topk_select
// Directed bench for wtsum_topk_select with N_PATCH=16, TOP_K=4.
// Expected rankings are hand-computed per frame pattern.
`timescale 1ns/1ps
module tb_wtsum_topk_select;
  localparam int FP = 32;
  localparam int NP = 16;
  localparam int TK = 4;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  wtsum_topk_select_if #(.FP_SIZE(FP), .N_PATCH(NP), .TOP_K(TK)) bus ();

  wtsum_topk_select #(.DELAY(1), .FP_SIZE(FP), .N_PATCH(NP), .TOP_K(TK)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Count one comparison and report it if it mismatches.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Presented entry must match rank/patch/wtsum/last.
  task automatic entry(input int r, input int p, input int w, input bit last);
    chk("out_valid", 64'(bus.out_valid), 64'd1);
    chk("out_rank", 64'(bus.out_rank), 64'(r));
    chk("out_patch_num", 64'(bus.out_patch_num), 64'(p));
    chk("out_wtsum", 64'(bus.out_wtsum), 64'(w));
    chk("out_last", 64'(bus.out_last), 64'(last));
  endtask

  // mode 0: patch*3, mode 1: constant 7, mode 2: 100-patch
  function automatic logic [31:0] wval(input int mode, input int p);
    if (mode == 0) return 32'(p * 3);
    else if (mode == 1) return 32'd7;
    else return 32'(100 - p);
  endfunction

  // One frame of beats; skip omits a patch, out_ready rises at patch rdy_at.
  task automatic feed(input int mode, input int skip, input int rdy_at);
    for (int p = 0; p < NP; p++) begin
      if (p != skip) begin
        if (p == rdy_at) bus.out_ready = 1'b1;
        bus.in_valid     = 1'b1;
        bus.in_patch_num = 4'(p);
        bus.in_wtsum     = wval(mode, p);
        step();
      end
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_patch_num = '0;
    bus.in_wtsum     = '0;
    bus.out_ready    = 1'b0;
`ifdef TOPK_THRESHOLD_EN
    bus.min_wtsum    = '0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    // Reset state
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst out_last", 64'(bus.out_last), 64'd0);
    chk("rst frame_done", 64'(bus.frame_done), 64'd0);
    chk("rst seq_err", 64'(bus.seq_err), 64'd0);
    chk("rst overrun", 64'(bus.overrun), 64'd0);
    chk("rst out_rank", 64'(bus.out_rank), 64'd0);
    chk("rst out_patch_num", 64'(bus.out_patch_num), 64'd0);
    chk("rst out_wtsum", 64'(bus.out_wtsum), 64'd0);
    RESET = 1'b1;
    step();

    // 1: single frame, ready high, latency-1 drain
    bus.out_ready = 1'b1;
    feed(0, -1, 99);
    chk("t1 frame_done", 64'(bus.frame_done), 64'd1);
    entry(0, 15, 45, 1'b0); step();
    chk("t1 frame_done pulse", 64'(bus.frame_done), 64'd0);
    entry(1, 14, 42, 1'b0); step();
    entry(2, 13, 39, 1'b0); step();
    entry(3, 12, 36, 1'b1); step();
    chk("t1 idle", 64'(bus.out_valid), 64'd0);

    // 2: ties keep earlier patch first; hold under backpressure
    bus.out_ready = 1'b0;
    feed(1, -1, 99);
    entry(0, 0, 7, 1'b0);
    bus.out_ready = 1'b1; step();
    entry(1, 1, 7, 1'b0);
    bus.out_ready = 1'b0; step();
    entry(1, 1, 7, 1'b0); step();
    entry(1, 1, 7, 1'b0);
    bus.out_ready = 1'b1; step();
    entry(2, 2, 7, 1'b0); step();
    entry(3, 3, 7, 1'b1); step();
    chk("t2 idle", 64'(bus.out_valid), 64'd0);

    // 3a: second frame dropped while bank busy
    bus.out_ready = 1'b0;
    feed(0, -1, 99);
    entry(0, 15, 45, 1'b0);
    feed(2, -1, 99);
    chk("t3 overrun", 64'(bus.overrun), 64'd1);
    chk("t3 frame_done", 64'(bus.frame_done), 64'd1);
    chk("t3 seq_err", 64'(bus.seq_err), 64'd0);
    entry(0, 15, 45, 1'b0);
    bus.out_ready = 1'b1; step();
    entry(1, 14, 42, 1'b0); step();
    entry(2, 13, 39, 1'b0);

    // 5: async reset mid-drain
    RESET = 1'b0;
    #0.5;
    chk("t5 out_valid in reset", 64'(bus.out_valid), 64'd0);
    chk("t5 overrun in reset", 64'(bus.overrun), 64'd0);
    #0.5;
    RESET = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) step();
    chk("t5 no output after reset", 64'(bus.out_valid), 64'd0);

    // 3b: last transfer coincides with next snapshot -> no overrun
    feed(0, -1, 99);
    entry(0, 15, 45, 1'b0);
    feed(2, -1, 12);
    chk("t3b overrun", 64'(bus.overrun), 64'd0);
    chk("t3b frame_done", 64'(bus.frame_done), 64'd1);
    entry(0, 0, 100, 1'b0); step();
    entry(1, 1, 99, 1'b0); step();
    entry(2, 2, 98, 1'b0); step();
    entry(3, 3, 97, 1'b1); step();
    chk("t3b idle", 64'(bus.out_valid), 64'd0);

    // 4: skipped patch flags seq_err, frame still ends on patch 15
    chk("t4 seq_err before", 64'(bus.seq_err), 64'd0);
    bus.out_ready = 1'b1;
    feed(0, 5, 99);
    chk("t4 seq_err", 64'(bus.seq_err), 64'd1);
    chk("t4 frame_done", 64'(bus.frame_done), 64'd1);
    entry(0, 15, 45, 1'b0); step();
    entry(1, 14, 42, 1'b0); step();
    entry(2, 13, 39, 1'b0); step();
    entry(3, 12, 36, 1'b1); step();
    chk("t4 idle", 64'(bus.out_valid), 64'd0);

`ifdef TOPK_THRESHOLD_EN
    // 6: threshold leaves only two entries
    RESET = 1'b0;
    #1;
    RESET = 1'b1;
    step();
    bus.min_wtsum = 32'd40;
    bus.out_ready = 1'b1;
    feed(0, -1, 99);
    entry(0, 15, 45, 1'b0); step();
    entry(1, 14, 42, 1'b1); step();
    chk("t6 idle", 64'(bus.out_valid), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
